// File: rtl/jtframe_osd_tx.sv
// ============================================================================
// jtframe_osd_tx
// ----------------------------------------------------------------------------
// Initiator side of the OSD command bus. Frames a transaction with io_osd,
// sends a command byte followed by payload words, and qualifies every word
// with a one-cycle io_strobe pulse. Supports enable, disable, info-box and
// character-buffer row writes (rows are streamed from a synchronous RAM).
//
// Parameters:
//   STB_GAP    low cycles after each strobe (values below 1 act as 1)
//   FRAME_GAP  cycles io_osd is held low after a transaction before done
//              (values below 1 act as 1)
//
// Ports:
//   clk_sys            in   system clock, rising edge
//   rst_n              in   asynchronous active-low reset
//   req                in   start request, sampled only in IDLE
//   op[1:0]            in   0 disable, 1 enable, 2 info box, 3 buffer write
//   row[4:0]           in   start row for a write
//   nrows[3:0]         in   rows to write minus 1
//   info_x/info_y      in   info-box position (12 bits each)
//   info_w/info_h      in   info-box size in 8-pixel units (6 bits each)
//   rot[1:0]           in   rotation code sent with info
//   buf_addr[12:0]     out  character RAM read address
//   buf_data[7:0]      in   RAM read data, one-cycle latency
//   busy               out  transaction in progress
//   done               out  one-cycle end-of-transaction pulse
//   io_osd             out  transaction frame
//   io_strobe          out  word qualifier
//   io_din[15:0]       out  word bus
// ============================================================================
module jtframe_osd_tx #(
    parameter int STB_GAP   = 1,
    parameter int FRAME_GAP = 2
) (
    input  logic        clk_sys,
    input  logic        rst_n,
    input  logic        req,
    input  logic [1:0]  op,
    input  logic [4:0]  row,
    input  logic [3:0]  nrows,
    input  logic [11:0] info_x,
    input  logic [11:0] info_y,
    input  logic [5:0]  info_w,
    input  logic [5:0]  info_h,
    input  logic [1:0]  rot,
    output logic [12:0] buf_addr,
    input  logic [7:0]  buf_data,
    output logic        busy,
    output logic        done,
    output logic        io_osd,
    output logic        io_strobe,
    output logic [15:0] io_din
);

    localparam int SG = (STB_GAP   < 1) ? 1 : STB_GAP;
    localparam int FG = (FRAME_GAP < 1) ? 1 : FRAME_GAP;

    localparam logic [15:0] GAP_LOAD   = 16'(SG - 1);
    localparam logic [15:0] CLOSE_LOAD = 16'(FG - 1);

    localparam logic [1:0] OP_DIS  = 2'd0;
    localparam logic [1:0] OP_EN   = 2'd1;
    localparam logic [1:0] OP_INFO = 2'd2;
    localparam logic [1:0] OP_WR   = 2'd3;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETUP  = 3'd1;
    localparam logic [2:0] S_STROBE = 3'd2;
    localparam logic [2:0] S_GAP    = 3'd3;
    localparam logic [2:0] S_CLOSE  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    // Command byte for an operation, zero-extended to the bus width.
    function automatic logic [15:0] cmd_word(input logic [1:0] f_op,
                                             input logic [4:0] f_row);
        logic [15:0] w;
        case (f_op)
            OP_DIS:  w = 16'h0040;
            OP_EN:   w = 16'h0041;
            OP_INFO: w = 16'h0045;
            OP_WR:   w = 16'h0020 | {11'd0, f_row};
            default: w = 16'h0000;
        endcase
        return w;
    endfunction

    // Index of the final word of a transaction (word 0 is the command).
    function automatic logic [13:0] last_index(input logic [1:0] f_op,
                                               input logic [3:0] f_nrows);
        logic [13:0] l;
        case (f_op)
            OP_INFO: l = 14'd5;
            OP_WR:   l = {2'b00, f_nrows, 8'hFF} + 14'd1;
            default: l = 14'd0;
        endcase
        return l;
    endfunction

    // Info-box payload word for word index 1..5.
    function automatic logic [15:0] info_word(input logic [13:0] f_idx,
                                              input logic [11:0] f_x,
                                              input logic [11:0] f_y,
                                              input logic [5:0]  f_w,
                                              input logic [5:0]  f_h,
                                              input logic [1:0]  f_rot);
        logic [15:0] w;
        case (f_idx)
            14'd1:   w = {4'b0, f_x};
            14'd2:   w = {4'b0, f_y};
            14'd3:   w = {10'b0, f_w};
            14'd4:   w = {10'b0, f_h};
            14'd5:   w = {14'b0, f_rot};
            default: w = 16'h0000;
        endcase
        return w;
    endfunction

    logic [2:0]  r_state;
    logic [1:0]  r_op;
    logic [4:0]  r_row;
    logic [11:0] r_x;
    logic [11:0] r_y;
    logic [5:0]  r_w;
    logic [5:0]  r_h;
    logic [1:0]  r_rot;
    logic [13:0] r_last;
    logic [13:0] r_wcnt;
    logic [15:0] r_gcnt;
    logic [15:0] r_ccnt;
    logic [12:0] r_addr;
    logic        r_busy;
    logic        r_done;
    logic        r_osd;
    logic        r_strobe;
    logic [15:0] r_din;

    logic [12:0] w_next_addr;
    logic [13:0] w_wcnt_inc;

    // Address of data word r_wcnt (data word k follows word index k); wraps at 2^13.
    assign w_next_addr = {r_row, 8'h00} + r_wcnt[12:0];
    assign w_wcnt_inc  = r_wcnt + 14'd1;

    // Transaction sequencer; all bus outputs are registered alongside the state.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_op     <= 2'd0;
            r_row    <= 5'd0;
            r_x      <= 12'd0;
            r_y      <= 12'd0;
            r_w      <= 6'd0;
            r_h      <= 6'd0;
            r_rot    <= 2'd0;
            r_last   <= 14'd0;
            r_wcnt   <= 14'd0;
            r_gcnt   <= 16'd0;
            r_ccnt   <= 16'd0;
            r_addr   <= 13'd0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_osd    <= 1'b0;
            r_strobe <= 1'b0;
            r_din    <= 16'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (req) begin
                        r_op    <= op;
                        r_row   <= row;
                        r_x     <= info_x;
                        r_y     <= info_y;
                        r_w     <= info_w;
                        r_h     <= info_h;
                        r_rot   <= rot;
                        r_last  <= last_index(op, nrows);
                        r_wcnt  <= 14'd0;
                        r_din   <= cmd_word(op, row);
                        r_osd   <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= S_SETUP;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_SETUP: begin
                    // RAM data for this word became valid during SETUP.
                    if ((r_op == OP_WR) && (r_wcnt != 14'd0)) begin
                        r_din <= {8'h00, buf_data};
                    end else begin
                        r_din <= r_din;
                    end
                    r_strobe <= 1'b1;
                    r_state  <= S_STROBE;
                end
                S_STROBE: begin
                    r_strobe <= 1'b0;
                    r_gcnt   <= GAP_LOAD;
                    // Present the next word's address a full GAP ahead of its SETUP.
                    if ((r_op == OP_WR) && (r_wcnt != r_last)) begin
                        r_addr <= w_next_addr;
                    end else begin
                        r_addr <= r_addr;
                    end
                    r_state <= S_GAP;
                end
                S_GAP: begin
                    if (r_gcnt != 16'd0) begin
                        r_gcnt <= r_gcnt - 16'd1;
                    end else if (r_wcnt == r_last) begin
                        r_osd   <= 1'b0;
                        r_din   <= 16'd0;
                        r_ccnt  <= CLOSE_LOAD;
                        r_state <= S_CLOSE;
                    end else begin
                        r_wcnt <= w_wcnt_inc;
                        if (r_op == OP_INFO) begin
                            r_din <= info_word(w_wcnt_inc, r_x, r_y, r_w, r_h, r_rot);
                        end else begin
                            r_din <= r_din;
                        end
                        r_state <= S_SETUP;
                    end
                end
                S_CLOSE: begin
                    if (r_ccnt != 16'd0) begin
                        r_ccnt <= r_ccnt - 16'd1;
                    end else begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    // req is deliberately not sampled here.
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_busy   <= 1'b0;
                    r_done   <= 1'b0;
                    r_osd    <= 1'b0;
                    r_strobe <= 1'b0;
                    r_din    <= 16'd0;
                end
            endcase
        end
    end

    assign buf_addr  = r_addr;
    assign busy      = r_busy;
    assign done      = r_done;
    assign io_osd    = r_osd;
    assign io_strobe = r_strobe;
    assign io_din    = r_din;

endmodule
